pll_lock_supervisor: RTL and testbench

//  Drives the PLL reset input and consumes the PLL locked output (other end of the PLL rst/locked handshake).

---
 rtl/pll_lock_supervisor.sv | 131 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor on the board reference clock: pulses the PLL reset, waits for a
// debounced lock with timeout/retry, then releases the system reset for PLL-clocked logic.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fail,
  output logic [RW-1:0] retry_count,
  output logic [7:0]    lock_loss_count
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW  = $clog2(STABLE_CYCLES + 1);
  localparam logic [RCW-1:0] RC_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]  T_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0]  S_LAST    = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      llc_q, llc_d;
  logic            pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic            lk, timeout;

  assign lk = sync2_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    llc_d   = llc_q;
    timeout = 1'b0;
    unique case (state_q)
      S_RESET_PLL: if (rcnt_q == RC_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lk)                    state_d = S_STABLE;
        else if (tcnt_q >= T_LAST) timeout = 1'b1;
      end
      // The timeout is checked first so neither lock bounce nor a late completion can evade it.
      S_STABLE: begin
        if (tcnt_q >= T_LAST) timeout = 1'b1;
        else if (!lk)         state_d = S_WAIT_LOCK;
        else if (scnt_q == S_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_d = S_RESET_PLL;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_RESET_PLL;
    endcase
    if (timeout) begin
      retry_d = retry_q + 1'b1;
      state_d = (retry_d == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
    end

    rcnt_d = (state_q == S_RESET_PLL) ? rcnt_q + 1'b1 : '0;
    scnt_d = (state_q == S_STABLE)    ? scnt_q + 1'b1 : '0;
    if (state_d == S_RESET_PLL)
      tcnt_d = '0;
    else if (state_q == S_WAIT_LOCK || state_q == S_STABLE)
      tcnt_d = tcnt_q + 1'b1;
    else
      tcnt_d = tcnt_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      retry_q   <= '0;
      llc_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= pll_locked;
      sync2_q   <= sync1_q;
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      retry_q   <= retry_d;
      llc_q     <= llc_d;
      // Outputs decode the next state so they change on the same edge as the state register.
      pll_rst_q <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: table-driven bring-up/relock vectors plus
// hand-written timeout, lock-bounce, reset-abort and saturation sequences.
module tb_pll_lock_supervisor;
  localparam int RC = 4;
  localparam int LT = 50;
  localparam int SC = 8;
  localparam int MR = 3;
  localparam int RW = $clog2(MR + 1);

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          pll_rst, sys_rst, ready, fail;
  logic [RW-1:0] retry_count;
  logic [7:0]    lock_loss_count;

  int checks = 0;
  int failures = 0;
  int tcur = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic        lk;
    int          n;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [13:0] pack(input logic p, input logic s, input logic r,
                                       input logic f, input logic [1:0] rc, input logic [7:0] l);
    return {p, s, r, f, rc, l};
  endfunction

  function automatic logic [13:0] outs();
    return {pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count};
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
    tcur++;
  endtask

  task automatic run_to(input int t);
    while (tcur < t) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, tcur);
    end
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    tick();
    chk(nm, {18'd0, outs()}, {18'd0, pack(1, 1, 0, 0, 2'd0, 8'd0)});
    tick();
    rst = 1'b0;
    tcur = 0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = ready;
  endtask

  initial begin
    bit ok;
    bit seen;

    // Bring-up with lock 10 cycles after pll_rst falls, then a 1-cycle lock drop in RUN.
    tbl[0]  = '{0, 3,  pack(1, 1, 0, 0, 2'd0, 8'd0)};
    tbl[1]  = '{0, 1,  pack(0, 1, 0, 0, 2'd0, 8'd0)};
    tbl[2]  = '{0, 9,  pack(0, 1, 0, 0, 2'd0, 8'd0)};
    tbl[3]  = '{1, 10, pack(0, 1, 0, 0, 2'd0, 8'd0)};
    tbl[4]  = '{1, 1,  pack(0, 0, 1, 0, 2'd0, 8'd0)};
    tbl[5]  = '{1, 20, pack(0, 0, 1, 0, 2'd0, 8'd0)};
    tbl[6]  = '{0, 1,  pack(0, 0, 1, 0, 2'd0, 8'd0)};
    tbl[7]  = '{1, 1,  pack(0, 0, 1, 0, 2'd0, 8'd0)};
    tbl[8]  = '{1, 1,  pack(1, 1, 0, 0, 2'd0, 8'd1)};
    tbl[9]  = '{1, 3,  pack(1, 1, 0, 0, 2'd0, 8'd1)};
    tbl[10] = '{1, 1,  pack(0, 1, 0, 0, 2'd0, 8'd1)};
    tbl[11] = '{1, 8,  pack(0, 1, 0, 0, 2'd0, 8'd1)};
    tbl[12] = '{1, 1,  pack(0, 0, 1, 0, 2'd0, 8'd1)};

    pll_locked = 1'b0;
    tick();
    do_reset("reset_initial");
    for (int i = 0; i < 13; i++) begin
      pll_locked = tbl[i].lk;
      for (int k = 0; k < tbl[i].n; k++) tick();
      chk($sformatf("vec%0d", i), {18'd0, outs()}, {18'd0, tbl[i].exp});
    end

    // rst while in RUN clears everything including the lock-loss count.
    do_reset("reset_in_run");

    // Lock toggling every 5 cycles from WAIT_LOCK never completes and times out at t=54.
    pll_locked = 1'b0;
    seen = 1'b0;
    run_to(4);
    while (tcur < 53) begin
      pll_locked = (((tcur - 4) / 5) % 2) == 0;
      tick();
      if (ready) seen = 1'b1;
    end
    chk("toggle_pre_timeout", {30'd0, pll_rst, retry_count}, {30'd0, 1'b0, 2'd0});
    pll_locked = 1'b0;
    tick();
    chk("toggle_timeout", {29'd0, pll_rst, sys_rst, retry_count}, {29'd0, 1'b1, 1'b1, 2'd1});
    chk("toggle_never_ready", {31'd0, seen}, 32'd0);

    // Lock never arrives: three timeouts end in sticky FAIL.
    pll_locked = 1'b0;
    do_reset("reset_before_nolock");
    run_to(53);
    chk("nolock_t53", {30'd0, pll_rst, retry_count}, {30'd0, 1'b0, 2'd0});
    run_to(54);
    chk("nolock_to1", {30'd0, pll_rst, retry_count}, {30'd0, 1'b1, 2'd1});
    run_to(57);
    chk("nolock_pulse2_hi", {31'd0, pll_rst}, 32'd1);
    run_to(58);
    chk("nolock_pulse2_lo", {31'd0, pll_rst}, 32'd0);
    run_to(107);
    chk("nolock_t107", {30'd0, fail, retry_count}, {30'd0, 1'b0, 2'd1});
    run_to(108);
    chk("nolock_to2", {30'd0, pll_rst, retry_count}, {30'd0, 1'b1, 2'd2});
    run_to(161);
    chk("nolock_t161", {31'd0, fail}, 32'd0);
    run_to(162);
    chk("nolock_fail", {18'd0, outs()}, {18'd0, pack(1, 1, 0, 1, 2'd3, 8'd0)});
    pll_locked = 1'b1;
    run_to(202);
    chk("fail_sticky", {18'd0, outs()}, {18'd0, pack(1, 1, 0, 1, 2'd3, 8'd0)});

    // rst while in FAIL.
    do_reset("reset_in_fail");

    // 300 lock-loss events: count saturates at 255.
    wait_ready(ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL sat_initial_ready: ready never rose within bound");
    end
    for (int e = 1; e <= 300; e++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      tick();
      wait_ready(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL sat_relock: no RUN after event %0d", e);
        break;
      end
      if (e == 254) chk("llc_254", {24'd0, lock_loss_count}, 32'd254);
      if (e == 255) chk("llc_255", {24'd0, lock_loss_count}, 32'd255);
    end
    chk("llc_saturated", {24'd0, lock_loss_count}, 32'd255);
    chk("sat_run_state", {18'd0, outs()}, {18'd0, pack(0, 0, 1, 0, 2'd0, 8'd255)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
